// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and constants for the sequential multiplier
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// rtl/seq_mult_datapath.sv - M/HI/LO/carry registers with the WIDTH+1 adder and right shifter
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               add_i,
  input  logic [WIDTH-1:0]   m_i,
  input  logic [WIDTH-1:0]   q_i,
  output logic               lo0_o,
  output logic [2*WIDTH-1:0] prod_next_o
);

  logic [WIDTH-1:0] m_q, hi_q, lo_q;
  logic             carry_q;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             carry_d;

  // {carry,HI} is the accumulator, so the sum never overflows before the shift.
  always_comb begin
    acc = {carry_q, hi_q};
    if (add_i) begin
      acc = acc + {1'b0, m_q};
    end
    {carry_d, hi_d, lo_d} = {1'b0, acc, lo_q[WIDTH-1:1]};
    prod_next_o = {hi_d, lo_d};
  end

  assign lo0_o = lo_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      carry_q <= 1'b0;
    end else if (load_i) begin
      m_q     <= m_i;
      hi_q    <= '0;
      lo_q    <= q_i;
      carry_q <= 1'b0;
    end else if (step_i) begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier top: FSM, step counter and registered outputs
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               valid,
  output logic               busy
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e               state_q;
  logic [CW-1:0]        count_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 valid_q, busy_q;

  logic                 load, step, lo0;
  logic [2*WIDTH-1:0]   prod_next;

  // A start always wins over an iteration step in the same cycle.
  assign load = start;
  assign step = (state_q == RUN) && !start;

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_i      (step),
    .add_i       (step && lo0),
    .m_i         (multiplicand),
    .q_i         (multiplier),
    .lo0_o       (lo0),
    .prod_next_o (prod_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else if (start) begin
      state_q <= RUN;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          count_q <= count_q + CW'(1);
          if (count_q == LAST_STEP) begin
            state_q   <= DONE;
            product_q <= prod_next;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign product = product_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           valid;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .valid        (valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return 32'(int'(a) * int'(b));
  endfunction

  // Called just after the last start edge: expects busy for W edges, then the result.
  task automatic wait_result(input logic [31:0] exp, input string tag);
    for (int k = 0; k < W; k++) begin
      check_eq({tag, " busy/valid"}, 32'({busy, valid}), 32'b10);
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      tick();
    end
    check_eq({tag, " done busy/valid"}, 32'({busy, valid}), 32'b01);
    check_eq({tag, " product"}, 32'(product), exp);
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    wait_result(ref_mul(a, b), tag);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset product", 32'(product), 32'h0);
    check_eq("reset busy/valid", 32'({busy, valid}), 32'b00);
    tick();
    check_eq("idle busy/valid", 32'({busy, valid}), 32'b00);

    run_job(8'd13, 8'd11, "13x11");
    check_eq("13x11 literal", 32'(product), 32'h008F);
    run_job(8'd255, 8'd255, "255x255");
    check_eq("255x255 literal", 32'(product), 32'hFE01);
    run_job(8'd0, 8'd200, "0x200");
    check_eq("0x200 literal", 32'(product), 32'h0000);
    run_job(8'd1, 8'd200, "1x200");
    check_eq("1x200 literal", 32'(product), 32'h00C8);
    run_job(8'd200, 8'd0, "200x0");
    check_eq("200x0 literal", 32'(product), 32'h0000);

    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("done hold busy/valid", 32'({busy, valid}), 32'b01);
      check_eq("done hold product", 32'(product), 32'h0000);
    end

    multiplicand = 8'd13;
    multiplier   = 8'd11;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("restart first job valid", 32'(valid), 32'h0);
    end
    run_job(8'd7, 8'd9, "restart 7x9");
    check_eq("restart literal", 32'(product), 32'h003F);

    multiplicand = 8'd13;
    multiplier   = 8'd11;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrun reset product", 32'(product), 32'h0);
    check_eq("midrun reset busy/valid", 32'({busy, valid}), 32'b00);
    tick();
    check_eq("post reset idle", 32'({busy, valid}), 32'b00);
    run_job(8'd3, 8'd5, "3x5");
    check_eq("3x5 literal", 32'(product), 32'h000F);

    multiplicand = 8'd2;
    multiplier   = 8'd2;
    start        = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("held start busy/valid", 32'({busy, valid}), 32'b10);
    end
    start = 1'b0;
    wait_result(32'h0004, "held start 2x2");

    // Back-to-back random jobs, each started in the first DONE cycle of the previous one.
    for (int n = 0; n < 25; n++) begin
      run_job(W'($urandom), W'($urandom), "random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
